clock_run_ctrl: RTL and testbench
=================================

# clock_run_ctrl

Run/stop/set controller that sequences the minutes counter of the digital clock. It divides the system clock down to a 1 s tick and keeps an internal seconds count (0–59). It drives the minutes counter's `enable` and `clear` inputs from that count and from front-panel button pulses. It sits between the synchronised button inputs and `minutes_counter`, and its outputs feed the display path.

## Interface
Parameters:
- `TICKS_PER_SEC`, default 50_000_000: `clk` cycles per second; minimum 2.
- `PRESC_W`, default $clog2(TICKS_PER_SEC): prescaler width.

Ports:
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `btn_start` in 1: single-cycle pulse; toggles run/stop.
- `btn_clear` in 1: single-cycle pulse; zeroes the time.
- `btn_set` in 1: single-cycle pulse; steps through the set fields.
- `btn_inc` in 1: single-cycle pulse; increments the selected field.
- `min_count` in 8: current minutes value from the minutes counter (0–99).
- `min_enable` out 1: one-cycle increment strobe to the minutes counter.
- `min_clear` out 1: one-cycle clear strobe to the minutes counter.
- `sec_count` out 6: seconds value, 0–59.
- `state` out 2: encoding STOP=0, RUN=1, SET_MIN=2, SET_SEC=3.
- `sec_tick` out 1: one-cycle pulse per elapsed second in RUN.
- `overflow` out 1: sticky flag; set when the minutes counter wraps from 99 to 0.

## Operation
- All outputs are registered. Reset values: `state`=STOP, prescaler=0, `sec_count`=0, and `min_enable`, `min_clear`, `sec_tick`, `overflow` all 0. `min_clear` is not pulsed at reset, because the minutes counter shares `rst_n`.
- FSM transitions:
  - STOP: `btn_start` goes to RUN; `btn_set` goes to SET_MIN.
  - RUN: `btn_start` goes to STOP; `btn_set` and `btn_inc` are ignored.
  - SET_MIN: `btn_set` goes to SET_SEC; `btn_inc` raises `min_enable` for one cycle.
  - SET_SEC: `btn_set` goes to STOP; `btn_inc` does `sec_count` +1, wrapping 59 to 0 with no carry.
  - `btn_start` is ignored in both SET states.
- Clear, from any state: `btn_clear` sets `state`=STOP, `sec_count`=0, prescaler=0, `overflow`=0, and raises `min_clear` for one cycle. Clear has top priority over every other input and over a coincident tick. On that edge no `min_enable` or `sec_tick` is issued.
- Prescaler:
  - Counts only while `state`==RUN.
  - Holds its value in STOP, SET_MIN and SET_SEC, so pause/resume keeps the sub-second phase.
  - Is zeroed only by reset and by `btn_clear`.
- Tick edge, defined as `state`==RUN with prescaler==TICKS_PER_SEC-1:
  - Prescaler goes to 0 and `sec_tick` goes to 1.
  - If `sec_count`==59: `sec_count` goes to 0, `min_enable` goes to 1, and `overflow` goes to 1 if `min_count`==99. Otherwise `sec_count` +1.
- A tick coincident with `btn_start` in RUN is fully applied; `state` still becomes STOP.
- `overflow` is set only by a RUN carry, never by a SET_MIN increment.
- Arithmetic: `sec_count` never exceeds 59. The prescaler never exceeds TICKS_PER_SEC-1.

## Timing
- Button to `state`: 1 cycle. The new state is visible after the edge that samples the pulse.
- RUN entered with prescaler=0: the first `sec_tick` is high in cycle TICKS_PER_SEC after `state` reads RUN.
- Between two consecutive ticks in uninterrupted RUN there are exactly TICKS_PER_SEC cycles.
- `min_enable` and `min_clear` are high for exactly one cycle.
- The minutes counter updates on the edge after the strobe is seen, so `min_count` lags the strobe by 1 cycle.
- `min_count` is sampled on the carry edge, before the minutes counter increments.
- Asynchronous reset asserted mid-RUN forces all outputs to their reset values immediately, without waiting for a clock edge.

## Structure
- Shared package `clock_pkg` holds:
  - the state encoding, as a typedef for the 2-bit `state`;
  - `SEC_MAX`=59;
  - `MIN_MAX`=99, shared with the minutes counter.
- Sub-module `tick_prescaler`:
  - Inputs: `clk`, `rst_n`, `run`, `clr`.
  - Output: `tick` at terminal count.
  - Parameter: `TICKS_PER_SEC`.
- The FSM, the seconds counter and the strobe/overflow logic stay in `clock_run_ctrl`.

## Test plan
All scenarios use TICKS_PER_SEC=4.
- Single tick: reset, then pulse `btn_start`. Required: `state`=RUN next cycle; `sec_tick` pulses every 4 cycles; `sec_count` goes 0→1→2.
- Minute carry: run for 60 ticks. Required: `sec_count` wraps 59→0; exactly one `min_enable` pulse, on the wrap edge.
- Overflow: hold `min_count`=99 through a carry. Required: `overflow`=1 and stays set. Then pulse `btn_clear`. Required: `overflow`=0, one `min_clear` pulse, `sec_count`=0, `state`=STOP.
- Set mode:
  - From STOP, pulse `btn_set`. Required: SET_MIN.
  - Pulse `btn_inc` 3 times. Required: 3 `min_enable` pulses and no `overflow`.
  - Pulse `btn_set`. Required: SET_SEC.
  - Pulse `btn_inc` 60 times from 0. Required: `sec_count`=0 and no `min_enable`.
  - Pulse `btn_set`. Required: STOP.
- Simultaneous events:
  - `btn_start` and `btn_clear` together in RUN. Required: STOP with `sec_count`=0.
  - `btn_start` coincident with a tick. Required: `sec_count` increments and `state`=STOP.
  - Stop at prescaler=2, then resume. Required: next tick 2 cycles later.
- Async reset: assert `rst_n`=0 mid-RUN at `sec_count`=30, between clock edges. Required: all outputs at reset values before the next edge.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared definitions for the digital clock: run/set state encoding and field limits.
package clock_pkg;

   typedef enum logic [1:0] {
      ST_STOP    = 2'd0,
      ST_RUN     = 2'd1,
      ST_SET_MIN = 2'd2,
      ST_SET_SEC = 2'd3
   } state_t;

   localparam logic [5:0] SEC_MAX = 6'd59;
   localparam logic [7:0] MIN_MAX = 8'd99;

   // Seconds increment that wraps SEC_MAX back to zero.
   function automatic logic [5:0] sec_wrap_inc(input logic [5:0] s);
      return (s == SEC_MAX) ? 6'd0 : s + 6'd1;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-per-second terminal-count tick; holds its phase while not running.
module tick_prescaler #(
   parameter int TICKS_PER_SEC = 50_000_000,
   parameter int PRESC_W       = $clog2(TICKS_PER_SEC)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic clr,
   output logic tick
);

   localparam logic [PRESC_W-1:0] TERM = PRESC_W'(TICKS_PER_SEC - 1);

   logic [PRESC_W-1:0] presc;

   assign tick = run && (presc == TERM);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
      end else if (clr) begin
         presc <= '0;
      end else if (run) begin
         presc <= tick ? '0 : presc + PRESC_W'(1);
      end
   end

endmodule

// File: rtl/clock_run_ctrl.sv
// Run/stop/set sequencer for the minutes counter: seconds count, enable/clear strobes, overflow flag.
module clock_run_ctrl
   import clock_pkg::*;
#(
   parameter int TICKS_PER_SEC = 50_000_000,
   parameter int PRESC_W       = $clog2(TICKS_PER_SEC)
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_start,
   input  logic       btn_clear,
   input  logic       btn_set,
   input  logic       btn_inc,
   input  logic [7:0] min_count,
   output logic       min_enable,
   output logic       min_clear,
   output logic [5:0] sec_count,
   output logic [1:0] state,
   output logic       sec_tick,
   output logic       overflow
);

   state_t     state_q;
   state_t     state_nxt;
   logic       tick;
   logic [5:0] sec_d;
   logic       min_enable_d;
   logic       min_clear_d;
   logic       sec_tick_d;
   logic       overflow_d;

   assign state = state_q;

   tick_prescaler #(
      .TICKS_PER_SEC (TICKS_PER_SEC),
      .PRESC_W       (PRESC_W)
   ) u_presc (
      .clk   (clk),
      .rst_n (rst_n),
      .run   (state_q == ST_RUN),
      .clr   (btn_clear),
      .tick  (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_STOP;
         sec_count  <= '0;
         min_enable <= 1'b0;
         min_clear  <= 1'b0;
         sec_tick   <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         state_q    <= state_nxt;
         sec_count  <= sec_d;
         min_enable <= min_enable_d;
         min_clear  <= min_clear_d;
         sec_tick   <= sec_tick_d;
         overflow   <= overflow_d;
      end
   end

   always_comb begin
      state_nxt = state_q;
      if (btn_clear) begin
         state_nxt = ST_STOP;
      end else begin
         case (state_q)
            ST_STOP: begin
               if (btn_start)    state_nxt = ST_RUN;
               else if (btn_set) state_nxt = ST_SET_MIN;
            end
            ST_RUN:     if (btn_start) state_nxt = ST_STOP;
            ST_SET_MIN: if (btn_set)   state_nxt = ST_SET_SEC;
            ST_SET_SEC: if (btn_set)   state_nxt = ST_STOP;
            default:    state_nxt = ST_STOP;
         endcase
      end
   end

   // Clear outranks a coincident tick; the tick path is only reachable in RUN.
   always_comb begin
      sec_d        = sec_count;
      min_enable_d = 1'b0;
      min_clear_d  = 1'b0;
      sec_tick_d   = 1'b0;
      overflow_d   = overflow;
      if (btn_clear) begin
         sec_d       = '0;
         overflow_d  = 1'b0;
         min_clear_d = 1'b1;
      end else if (tick) begin
         sec_tick_d = 1'b1;
         sec_d      = sec_wrap_inc(sec_count);
         if (sec_count == SEC_MAX) begin
            min_enable_d = 1'b1;
            if (min_count == MIN_MAX) overflow_d = 1'b1;
         end
      end else if (btn_inc && (state_q == ST_SET_MIN)) begin
         min_enable_d = 1'b1;
      end else if (btn_inc && (state_q == ST_SET_SEC)) begin
         sec_d = sec_wrap_inc(sec_count);
      end
   end

endmodule

// File: tb/tb_clock_run_ctrl.sv
// Directed bench for clock_run_ctrl at TICKS_PER_SEC=4; inputs change and outputs are sampled on negedge.
module tb_clock_run_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       btn_start = 1'b0;
   logic       btn_clear = 1'b0;
   logic       btn_set = 1'b0;
   logic       btn_inc = 1'b0;
   logic [7:0] min_count = 8'd0;
   logic       min_enable;
   logic       min_clear;
   logic [5:0] sec_count;
   logic [1:0] state;
   logic       sec_tick;
   logic       overflow;

   int checks = 0;
   int errors = 0;

   clock_run_ctrl #(.TICKS_PER_SEC(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_start  (btn_start),
      .btn_clear  (btn_clear),
      .btn_set    (btn_set),
      .btn_inc    (btn_inc),
      .min_count  (min_count),
      .min_enable (min_enable),
      .min_clear  (min_clear),
      .sec_count  (sec_count),
      .state      (state),
      .sec_tick   (sec_tick),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start();
      btn_start = 1'b1; step(1); btn_start = 1'b0;
   endtask

   task automatic pulse_set();
      btn_set = 1'b1; step(1); btn_set = 1'b0;
   endtask

   task automatic pulse_clear();
      btn_clear = 1'b1; step(1); btn_clear = 1'b0;
   endtask

   initial begin
      int n_en;
      int sec_at_en;

      step(2);
      check("rst_state", state, 0);
      check("rst_sec", sec_count, 0);
      check("rst_min_en", min_enable, 0);
      check("rst_min_clr", min_clear, 0);
      check("rst_tick", sec_tick, 0);
      check("rst_ovf", overflow, 0);
      rst_n = 1'b1;
      step(1);

      // single tick
      pulse_start();
      check("run_state", state, 1);
      step(3);
      check("tick1_early", sec_tick, 0);
      step(1);
      check("tick1", sec_tick, 1);
      check("sec1", sec_count, 1);
      step(1);
      check("tick1_low", sec_tick, 0);
      step(3);
      check("tick2", sec_tick, 1);
      check("sec2", sec_count, 2);

      // minute carry: 58 more ticks
      n_en = 0; sec_at_en = -1;
      for (int i = 0; i < 232; i++) begin
         step(1);
         if (min_enable) begin n_en++; sec_at_en = sec_count; end
      end
      check("carry_en_cnt", n_en, 1);
      check("carry_en_sec", sec_at_en, 0);
      check("carry_en_last", min_enable, 1);
      check("carry_sec", sec_count, 0);
      check("carry_no_ovf", overflow, 0);

      // overflow on carry with min_count=99
      min_count = 8'd99;
      n_en = 0;
      for (int i = 0; i < 240; i++) begin
         step(1);
         if (min_enable) n_en++;
      end
      check("ovf_en_cnt", n_en, 1);
      check("ovf_set", overflow, 1);
      step(1);
      min_count = 8'd0;
      step(2);
      check("ovf_sticky", overflow, 1);
      pulse_clear();
      check("clr_ovf", overflow, 0);
      check("clr_strobe", min_clear, 1);
      check("clr_sec", sec_count, 0);
      check("clr_state", state, 0);
      step(1);
      check("clr_strobe_1cyc", min_clear, 0);

      // set mode
      pulse_set();
      check("set_min", state, 2);
      n_en = 0;
      for (int i = 0; i < 3; i++) begin
         btn_inc = 1'b1; step(1); btn_inc = 1'b0;
         if (min_enable) n_en++;
         step(1);
         if (min_enable) n_en++;
      end
      check("setmin_en_cnt", n_en, 3);
      check("setmin_no_ovf", overflow, 0);
      pulse_set();
      check("set_sec", state, 3);
      n_en = 0;
      for (int i = 0; i < 60; i++) begin
         btn_inc = 1'b1; step(1); btn_inc = 1'b0;
         if (min_enable) n_en++;
         if (i == 58) check("setsec_59", sec_count, 59);
      end
      check("setsec_wrap", sec_count, 0);
      check("setsec_no_en", n_en, 0);
      pulse_set();
      check("set_stop", state, 0);

      // start + clear together in RUN
      pulse_start();
      step(4);
      check("pre_sc_sec", sec_count, 1);
      btn_start = 1'b1; btn_clear = 1'b1; step(1);
      btn_start = 1'b0; btn_clear = 1'b0;
      check("sc_state", state, 0);
      check("sc_sec", sec_count, 0);

      // start coincident with tick
      pulse_start();
      step(3);
      pulse_start();
      check("st_tick_sec", sec_count, 1);
      check("st_tick_state", state, 0);
      check("st_tick_pulse", sec_tick, 1);

      // stop with prescaler at 2, then resume
      pulse_start();
      step(1);
      pulse_start();
      check("pause_state", state, 0);
      step(5);
      check("pause_no_tick", sec_tick, 0);
      check("pause_sec", sec_count, 1);
      pulse_start();
      step(1);
      check("resume_early", sec_tick, 0);
      step(1);
      check("resume_tick", sec_tick, 1);
      check("resume_sec", sec_count, 2);

      // async reset mid-RUN at sec=30
      step(112);
      check("pre_rst_sec", sec_count, 30);
      check("pre_rst_tick", sec_tick, 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_state", state, 0);
      check("arst_sec", sec_count, 0);
      check("arst_tick", sec_tick, 0);
      check("arst_min_en", min_enable, 0);
      check("arst_min_clr", min_clear, 0);
      check("arst_ovf", overflow, 0);
      step(1);
      rst_n = 1'b1;
      step(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
